wine_feature_framer: RTL and testbench

- Sequential front/back end for the combinational printed white-wine MLP regressor. It is the producer of the regressor's packed 44-bit feature vector and the reader of its 21-bit result.
- Accepts 4-bit quantised features one per beat on a valid/ready stream and packs them into the feature vector, feature 0 at bits [3:0].
- Holds the vector stable for a settle window, samples the regressor output, then presents it on a valid/ready result stream.
- Also tracks frame and error statistics.

---
 rtl/wine_feature_framer_pkg.sv | 21 ++
 rtl/wine_feature_framer_if.sv | 39 +++
 rtl/wine_feature_framer.sv | 180 ++++++++++++++++++
 tb/tb_wine_feature_framer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/wine_feature_framer_pkg.sv
// Shared definitions for the wine-regressor feature framer: default widths,
// FSM state encoding and the packed-vector slot offset helper.
package wine_feature_framer_pkg;

    localparam int DEF_N_FEAT = 11;
    localparam int DEF_FEAT_W = 4;
    localparam int DEF_OUT_W  = 21;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        SETTLE  = 2'd2,
        HOLD    = 2'd3
    } framer_state_t;

    // Low bit of feature slot 'slot' inside the packed feature vector.
    function automatic int feat_slot_lo(input int slot, input int width);
        return slot * width;
    endfunction

endpackage

// File: rtl/wine_feature_framer_if.sv
// Feature-beat input stream and result output stream of the framer.
// The framer is the slave side; the feature producer / result consumer is the master.
interface wine_feature_framer_if
    import wine_feature_framer_pkg::*;
#(
    parameter int FEAT_W = DEF_FEAT_W,
    parameter int OUT_W  = DEF_OUT_W
) ();

    logic              s_valid;
    logic              s_ready;
    logic [FEAT_W-1:0] s_data;
    logic              s_last;

    logic              m_valid;
    logic              m_ready;
    logic [OUT_W-1:0]  m_data;

    modport slave (
        input  s_valid,
        output s_ready,
        input  s_data,
        input  s_last,
        output m_valid,
        input  m_ready,
        output m_data
    );

    modport master (
        output s_valid,
        input  s_ready,
        output s_data,
        output s_last,
        input  m_valid,
        output m_ready,
        input  m_data
    );

endinterface

// File: rtl/wine_feature_framer.sv
// Packs 4-bit feature beats into the regressor input vector, waits for the
// combinational core to settle, and hands the sampled result out on a stream.
module wine_feature_framer
    import wine_feature_framer_pkg::*;
#(
    parameter int N_FEAT     = DEF_N_FEAT,
    parameter int FEAT_W     = DEF_FEAT_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int SETTLE_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    wine_feature_framer_if.slave     bus,
    output logic [N_FEAT*FEAT_W-1:0] feat_vec,
    input  logic [OUT_W-1:0]         core_out,
    output logic                     frame_err,
    output logic [15:0]              frames_done,
    output logic [7:0]               err_cnt
);

    localparam int IDX_W = $clog2(N_FEAT);

    framer_state_t    state_reg;
    framer_state_t    state_next;
    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] idx_next;
    logic [3:0]       settle_cnt_reg;
    logic             m_valid_reg;
    logic [OUT_W-1:0] m_data_reg;
    logic             frame_err_reg;
    logic [15:0]      frames_done_reg;
    logic [7:0]       err_cnt_reg;

    logic s_ready_int;
    logic beat;
    logic collect_beat;
    logic last_slot;
    logic settle_done;
    logic frame_bad;
    logic result_taken;

    assign beat         = bus.s_valid && s_ready_int;
    assign collect_beat = beat && (state_reg == COLLECT);
    assign last_slot    = (idx_reg == IDX_W'(N_FEAT - 1));
    assign settle_done  = (state_reg == SETTLE) && (settle_cnt_reg == 4'(SETTLE_CYC - 1));
    assign result_taken = (state_reg == HOLD) && m_valid_reg && bus.m_ready;
    // Short frame (s_last early) and long frame (no s_last on the final slot) both
    // reduce to s_last disagreeing with whether the current slot is the last one.
    assign frame_bad    = collect_beat && (last_slot ^ bus.s_last);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= COLLECT;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            COLLECT: begin
                if (beat && last_slot) begin
                    state_next = bus.s_last ? SETTLE : DRAIN;
                end
            end
            DRAIN: begin
                if (beat && bus.s_last) begin
                    state_next = COLLECT;
                end
            end
            SETTLE: begin
                if (settle_done) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (result_taken) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        s_ready_int = 1'b0;
        case (state_reg)
            COLLECT, DRAIN: s_ready_int = 1'b1;
            default:        s_ready_int = 1'b0;
        endcase
    end

    assign bus.s_ready = s_ready_int;

    // ---------------- Slot index ----------------
    always_comb begin
        idx_next = idx_reg;
        if (collect_beat) begin
            idx_next = (!last_slot && !bus.s_last) ? idx_reg + IDX_W'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg <= '0;
        end else begin
            idx_reg <= idx_next;
        end
    end

    // ---------------- Feature slots ----------------
    // Each slot is its own register so only the addressed slot ever changes;
    // slots are deliberately not cleared between frames.
    for (genvar gi = 0; gi < N_FEAT; gi++) begin : g_slot
        logic [FEAT_W-1:0] slot_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_reg <= '0;
            end else if (collect_beat && (idx_reg == IDX_W'(gi))) begin
                slot_reg <= bus.s_data;
            end
        end

        assign feat_vec[feat_slot_lo(gi, FEAT_W) +: FEAT_W] = slot_reg;
    end

    // ---------------- Settle counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt_reg <= '0;
        end else if (state_reg == SETTLE) begin
            settle_cnt_reg <= settle_cnt_reg + 4'd1;
        end else begin
            settle_cnt_reg <= '0;
        end
    end

    // ---------------- Result register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
        end else if (settle_done) begin
            m_valid_reg <= 1'b1;
            m_data_reg  <= core_out;
        end else if (result_taken) begin
            m_valid_reg <= 1'b0;
        end
    end

    assign bus.m_valid = m_valid_reg;
    assign bus.m_data  = m_data_reg;

    // ---------------- Statistics ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_reg   <= 1'b0;
            frames_done_reg <= '0;
            err_cnt_reg     <= '0;
        end else begin
            frame_err_reg <= frame_bad;
            if (result_taken) begin
                frames_done_reg <= frames_done_reg + 16'd1;
            end
            if (frame_bad && (err_cnt_reg != 8'hFF)) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
        end
    end

    assign frame_err   = frame_err_reg;
    assign frames_done = frames_done_reg;
    assign err_cnt     = err_cnt_reg;

endmodule

// File: tb/tb_wine_feature_framer.sv
// Directed bench for wine_feature_framer with a simple stand-in for the regressor
// core: out = 104008 + sum(features) + 4096*feature10 (all-zero input gives 104008).
module tb_wine_feature_framer;

    logic        clk;
    logic        rst_n;
    logic [43:0] feat_vec;
    logic [20:0] core_out;
    logic        frame_err;
    logic [15:0] frames_done;
    logic [7:0]  err_cnt;

    int pass_cnt;
    int total_cnt;

    wine_feature_framer_if bus_if ();

    wine_feature_framer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_if.slave),
        .feat_vec    (feat_vec),
        .core_out    (core_out),
        .frame_err   (frame_err),
        .frames_done (frames_done),
        .err_cnt     (err_cnt)
    );

    function automatic logic [20:0] core_model(input logic [43:0] v);
        int acc;
        acc = 104008;
        for (int i = 0; i < 11; i++) acc += int'(v[i*4 +: 4]);
        acc += 4096 * int'(v[43:40]);
        return 21'(acc);
    endfunction

    assign core_out = core_model(feat_vec);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [3:0] data, input logic last);
        int wait_cyc;
        wait_cyc = 0;
        while (!bus_if.s_ready && wait_cyc < 50) begin
            tick();
            wait_cyc++;
        end
        if (!bus_if.s_ready) check("s_ready_timeout", 64'(bus_if.s_ready), 64'd1);
        bus_if.s_valid = 1'b1;
        bus_if.s_data  = data;
        bus_if.s_last  = last;
        tick();
        bus_if.s_valid = 1'b0;
        bus_if.s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [43:0] v);
        for (int i = 0; i < 11; i++) send_beat(v[i*4 +: 4], i == 10);
    endtask

    // Called #1 after the edge that accepted the last beat; returns cycles to m_valid.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!bus_if.m_valid && lat < 30) begin
            tick();
            lat++;
        end
        if (!bus_if.m_valid) check("m_valid_timeout", 64'(bus_if.m_valid), 64'd1);
    endtask

    task automatic handshake();
        bus_if.m_ready = 1'b1;
        tick();
        bus_if.m_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int          lat;
        int          bad;
        logic [20:0] cap_data;
        logic [43:0] cap_vec;

        pass_cnt       = 0;
        total_cnt      = 0;
        bus_if.s_valid = 1'b0;
        bus_if.s_data  = '0;
        bus_if.s_last  = 1'b0;
        bus_if.m_ready = 1'b0;
        do_reset();

        // Reset state
        check("rst_m_valid", 64'(bus_if.m_valid), 64'd0);
        check("rst_m_data", 64'(bus_if.m_data), 64'd0);
        check("rst_feat_vec", 64'(feat_vec), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_frames_done", 64'(frames_done), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        check("rst_s_ready", 64'(bus_if.s_ready), 64'd1);

        // All-zero frame
        send_frame(44'h0);
        wait_result(lat);
        $display("zero frame: latency=%0d m_data=%0d", lat, bus_if.m_data);
        check("zero_latency", 64'(lat), 64'd3);
        check("zero_m_data", 64'(bus_if.m_data), 64'd104008);
        handshake();
        check("zero_frames_done", 64'(frames_done), 64'd1);
        check("zero_m_valid_drop", 64'(bus_if.m_valid), 64'd0);
        check("zero_s_ready_back", 64'(bus_if.s_ready), 64'd1);

        // Packing: beat i carries i+1
        send_frame(44'hBA987654321);
        check("pack_s_ready_settle", 64'(bus_if.s_ready), 64'd0);
        check("pack_feat_vec", 64'(feat_vec), 64'hBA987654321);
        wait_result(lat);
        $display("packing frame: feat_vec=0x%0h m_data=%0d", feat_vec, bus_if.m_data);
        check("pack_m_data", 64'(bus_if.m_data), 64'd149130);
        handshake();
        check("pack_frames_done", 64'(frames_done), 64'd2);

        // Short frame: s_last on beat 5
        for (int i = 0; i < 5; i++) send_beat(4'd7, i == 4);
        $display("short frame: frame_err=%0d err_cnt=%0d", frame_err, err_cnt);
        check("short_frame_err", 64'(frame_err), 64'd1);
        check("short_err_cnt", 64'(err_cnt), 64'd1);
        check("short_feat_vec", 64'(feat_vec), 64'hBA987677777);
        tick();
        check("short_err_pulse_end", 64'(frame_err), 64'd0);
        check("short_no_m_valid", 64'(bus_if.m_valid), 64'd0);
        send_frame(44'h22222222222);
        wait_result(lat);
        $display("after short: m_data=%0d", bus_if.m_data);
        check("short_next_m_data", 64'(bus_if.m_data), 64'd112222);
        handshake();
        check("short_next_frames_done", 64'(frames_done), 64'd3);

        // Long frame: 14 beats, s_last only on 14
        for (int i = 0; i < 11; i++) send_beat(4'd3, 1'b0);
        $display("long frame: frame_err=%0d err_cnt=%0d", frame_err, err_cnt);
        check("long_frame_err", 64'(frame_err), 64'd1);
        check("long_err_cnt", 64'(err_cnt), 64'd2);
        check("long_s_ready_drain", 64'(bus_if.s_ready), 64'd1);
        for (int i = 11; i < 14; i++) send_beat(4'hF, i == 13);
        check("long_drain_feat_vec", 64'(feat_vec), 64'h33333333333);
        check("long_drain_err_cnt", 64'(err_cnt), 64'd2);
        check("long_drain_no_m_valid", 64'(bus_if.m_valid), 64'd0);
        send_frame(44'hA9876543210);
        check("long_next_feat_vec", 64'(feat_vec), 64'hA9876543210);
        wait_result(lat);
        $display("after long: m_data=%0d", bus_if.m_data);
        check("long_next_m_data", 64'(bus_if.m_data), 64'd145023);
        handshake();
        check("long_next_frames_done", 64'(frames_done), 64'd4);

        // Backpressure: 20 cycles in HOLD with m_ready low and s_valid pushing
        send_frame(44'h55555555555);
        wait_result(lat);
        cap_data       = bus_if.m_data;
        cap_vec        = feat_vec;
        bus_if.s_valid = 1'b1;
        bus_if.s_data  = 4'hF;
        bus_if.s_last  = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus_if.m_data !== cap_data || feat_vec !== cap_vec ||
                bus_if.m_valid !== 1'b1 || bus_if.s_ready !== 1'b0) bad++;
        end
        bus_if.s_valid = 1'b0;
        bus_if.s_last  = 1'b0;
        $display("backpressure: unstable_cycles=%0d m_data=%0d", bad, cap_data);
        check("bp_unstable_cycles", 64'(bad), 64'd0);
        check("bp_m_data", 64'(cap_data), 64'd124543);
        check("bp_frames_held", 64'(frames_done), 64'd4);
        handshake();
        check("bp_frames_done", 64'(frames_done), 64'd5);
        repeat (5) tick();
        check("bp_no_second_result", 64'(bus_if.m_valid), 64'd0);
        check("bp_frames_after", 64'(frames_done), 64'd5);

        // Asynchronous reset in the middle of SETTLE
        send_frame(44'h99999999999);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: feat_vec=0x%0h frames_done=%0d err_cnt=%0d", feat_vec, frames_done, err_cnt);
        check("arst_feat_vec", 64'(feat_vec), 64'd0);
        check("arst_m_valid", 64'(bus_if.m_valid), 64'd0);
        check("arst_m_data", 64'(bus_if.m_data), 64'd0);
        check("arst_frames_done", 64'(frames_done), 64'd0);
        check("arst_err_cnt", 64'(err_cnt), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        send_frame(44'h44444444444);
        wait_result(lat);
        $display("post reset frame: latency=%0d m_data=%0d", lat, bus_if.m_data);
        check("arst_next_latency", 64'(lat), 64'd3);
        check("arst_next_m_data", 64'(bus_if.m_data), 64'd120436);
        handshake();
        check("arst_next_frames_done", 64'(frames_done), 64'd1);

        // 256 one-beat short frames: counter saturates, pulse still fires
        for (int i = 0; i < 256; i++) send_beat(4'd1, 1'b1);
        $display("saturation: frame_err=%0d err_cnt=%0d", frame_err, err_cnt);
        check("sat_last_pulse", 64'(frame_err), 64'd1);
        check("sat_err_cnt", 64'(err_cnt), 64'd255);
        tick();
        check("sat_err_hold", 64'(err_cnt), 64'd255);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
